// File: rtl/i2c_s_if.sv
// I2C target interface: oversampled SCL/SDA, START/STOP detection, fixed 7-bit address match,
// write-byte strobes and read-byte requests toward user logic. Does not stretch the clock.
module i2c_s_if #(
    parameter logic [6:0] SLV_ADR = 7'h2A
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       wr_en,
    output logic [7:0] wr_data,
    output logic       wr_first,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t     state;
    logic [2:0] scl_sync;
    logic [2:0] sda_sync;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic       byte_done;
    logic       rw;
    logic       first_flag;
    logic       load_tx;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_cond;
    logic       stop_cond;
    logic       sda;

    // Two synchronizer stages plus one history stage; pure data path, no reset needed.
    always_ff @(posedge clk) begin
        scl_sync <= {scl_sync[1:0], scl_i};
        sda_sync <= {sda_sync[1:0], sda_i};
    end

    assign sda        = sda_sync[1];
    assign scl_rise   = scl_sync[1] & ~scl_sync[2];
    assign scl_fall   = ~scl_sync[1] & scl_sync[2];
    assign start_cond = scl_sync[1] & scl_sync[2] & ~sda_sync[1] & sda_sync[2];
    assign stop_cond  = scl_sync[1] & scl_sync[2] & sda_sync[1] & ~sda_sync[2];

    always_ff @(posedge clk) begin
        if (rstb) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            byte_done  <= 1'b0;
            rw         <= 1'b0;
            first_flag <= 1'b0;
            load_tx    <= 1'b0;
            sda_o      <= 1'b1;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            wr_first   <= 1'b0;
            rd_req     <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            rd_req    <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            load_tx   <= 1'b0;
            if (load_tx) tx_shift <= rd_data;

            if (start_cond) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                byte_done <= 1'b0;
                sda_o     <= 1'b1;
                start_det <= 1'b1;
                busy      <= 1'b1;
            end else if (stop_cond) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                byte_done <= 1'b0;
                sda_o     <= 1'b1;
                stop_det  <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ADDR, WR_DATA: begin
                        if (scl_rise) begin
                            rx_shift <= {rx_shift[6:0], sda};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            if (state == ADDR) begin
                                rw <= rx_shift[0];
                                if (rx_shift[7:1] == SLV_ADR) begin
                                    sda_o <= 1'b0;
                                    state <= ADDR_ACK;
                                    if (rx_shift[0]) begin
                                        rd_req  <= 1'b1;
                                        load_tx <= 1'b1;
                                    end
                                end else begin
                                    state <= IGNORE;
                                end
                            end else begin
                                wr_data    <= rx_shift;
                                wr_en      <= 1'b1;
                                wr_first   <= first_flag;
                                first_flag <= 1'b0;
                                sda_o      <= 1'b0;
                                state      <= WR_ACK;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                sda_o <= tx_shift[7];
                                state <= RD_DATA;
                            end else begin
                                sda_o      <= 1'b1;
                                first_flag <= 1'b1;
                                state      <= WR_DATA;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_o <= 1'b1;
                            state <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        // Bit 7 is already on the wire on entry; each fall presents the next one.
                        if (scl_fall) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                sda_o <= 1'b1;
                                state <= RD_ACK;
                            end else begin
                                sda_o    <= tx_shift[6];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda) begin
                                rd_req    <= 1'b1;
                                load_tx   <= 1'b1;
                                byte_done <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            sda_o     <= tx_shift[7];
                            state     <= RD_DATA;
                        end
                    end
                    IGNORE: sda_o <= 1'b1;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_s_if.sv
// Bench for i2c_s_if: a bit-level I2C master drives the bus, a negedge monitor logs DUT events,
// and expectations come from a transaction-level model of the target.
module tb_i2c_s_if;

    logic       clk = 1'b0;
    logic       rstb;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_o;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_first;
    logic       rd_req;
    logic [7:0] rd_data = 8'h00;
    logic       start_det;
    logic       stop_det;
    logic       busy;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;
    assign sda_bus = sda_m & sda_o;

    i2c_s_if #(.SLV_ADR(7'h2A)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .scl_i     (scl_m),
        .sda_i     (sda_bus),
        .sda_o     (sda_o),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_first  (wr_first),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .start_det (start_det),
        .stop_det  (stop_det),
        .busy      (busy)
    );

    // Event monitor and user-side read source.
    logic [8:0]  wr_mem [1024];
    logic [7:0]  rd_src [8];
    int unsigned rd_base = 0;
    int unsigned wr_tot = 0, rd_tot = 0, st_tot = 0, sp_tot = 0, low_tot = 0;

    always @(negedge clk) begin
        if (wr_en) begin
            wr_mem[wr_tot % 1024] <= {wr_first, wr_data};
            wr_tot <= wr_tot + 1;
        end
        if (rd_req) begin
            rd_data <= rd_src[(rd_tot - rd_base) % 8];
            rd_tot  <= rd_tot + 1;
        end
        if (start_det) st_tot <= st_tot + 1;
        if (stop_det)  sp_tot <= sp_tot + 1;
        if (!sda_o)    low_tot <= low_tot + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic w(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Bus master primitives; every bit starts 4 clk into SCL low.
    task automatic send_bit(input logic b, output logic s);
        sda_m = b; w(4);
        scl_m = 1'b1; w(4);
        s = sda_bus; w(4);
        scl_m = 1'b0; w(4);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(d[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        send_bit(nack, s);
    endtask

    task automatic start_c();
        sda_m = 1'b1; w(4);
        scl_m = 1'b1; w(8);
        sda_m = 1'b0; w(8);
        scl_m = 1'b0; w(4);
    endtask

    task automatic stop_c();
        sda_m = 1'b0; w(4);
        scl_m = 1'b1; w(8);
        sda_m = 1'b1; w(8);
    endtask

    // Transaction-level reference: what a target at 0x2A must do for a given request.
    function automatic void ref_model(input logic [6:0] adr, input logic rw, input int unsigned n,
                                      output logic ack, output int unsigned nwr, output int unsigned nrd);
        logic hit;
        hit = (adr == 7'h2A);
        ack = !hit;
        nwr = (hit && !rw) ? n : 0;
        nrd = (hit && rw) ? n : 0;
    endfunction

    // One complete START..STOP transaction; for reads, data is what the user side supplies.
    task automatic txn(input string tag, input logic [6:0] adr, input logic rw, input int unsigned n,
                       input logic [31:0] data, input logic exp_ack, input int unsigned exp_nwr,
                       input int unsigned exp_nrd);
        logic [7:0]  bytes [4];
        logic [7:0]  b;
        logic        ack;
        int unsigned wr0, st0, sp0, low0;
        for (int k = 0; k < 4; k++) bytes[k] = data[8*(3-k) +: 8];
        for (int k = 0; k < 4; k++) rd_src[k] = bytes[k];
        rd_base = rd_tot;
        wr0 = wr_tot; st0 = st_tot; sp0 = sp_tot; low0 = low_tot;
        start_c();
        check({tag, " busy_after_start"}, busy, 1);
        send_byte({adr, rw}, ack);
        check({tag, " addr_ack"}, ack, exp_ack);
        for (int k = 0; k < int'(n); k++) begin
            if (rw) begin
                recv_byte(k == int'(n) - 1, b);
                check($sformatf("%s rd_byte%0d", tag, k), b, exp_ack ? 8'hFF : bytes[k]);
            end else begin
                send_byte(bytes[k], ack);
                check($sformatf("%s wr_ack%0d", tag, k), ack, exp_ack);
            end
        end
        check({tag, " sda_released"}, sda_o, 1);
        stop_c();
        check({tag, " wr_count"}, wr_tot - wr0, exp_nwr);
        for (int k = 0; k < int'(exp_nwr); k++)
            check($sformatf("%s wr%0d", tag, k), wr_mem[(wr0 + k) % 1024], {k == 0, bytes[k]});
        check({tag, " rd_req_count"}, rd_tot - rd_base, exp_nrd);
        check({tag, " start_count"}, st_tot - st0, 1);
        check({tag, " stop_count"}, sp_tot - sp0, 1);
        check({tag, " sda_driven"}, (low_tot != low0), !exp_ack);
        check({tag, " busy_after_stop"}, busy, 0);
    endtask

    typedef struct {
        logic [6:0]  adr;
        logic        rw;
        int unsigned n;
        logic [31:0] data;
        logic        exp_ack;
        int unsigned exp_nwr;
        int unsigned exp_nrd;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic        s, ack, rack;
        logic [7:0]  b;
        logic [6:0]  radr;
        logic        rrw;
        int unsigned rn, rnwr, rnrd, wr0, st0, sp0, rd0;

        rstb = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        w(6);
        check("reset sda_o", sda_o, 1);
        check("reset wr_en", wr_en, 0);
        check("reset wr_data", wr_data, 0);
        check("reset wr_first", wr_first, 0);
        check("reset rd_req", rd_req, 0);
        check("reset start_det", start_det, 0);
        check("reset stop_det", stop_det, 0);
        check("reset busy", busy, 0);
        rstb = 1'b0;
        w(10);

        vecs[0] = '{7'h2A, 1'b0, 2, 32'hA53C0000, 1'b0, 2, 0};
        vecs[1] = '{7'h2B, 1'b0, 1, 32'h55000000, 1'b1, 0, 0};
        vecs[2] = '{7'h2A, 1'b1, 2, 32'h817E0000, 1'b0, 0, 2};
        vecs[3] = '{7'h2A, 1'b0, 1, 32'hFF000000, 1'b0, 1, 0};
        vecs[4] = '{7'h2A, 1'b1, 1, 32'h00000000, 1'b0, 0, 1};
        vecs[5] = '{7'h15, 1'b1, 1, 32'h12000000, 1'b1, 0, 0};
        vecs[6] = '{7'h2A, 1'b0, 4, 32'h0180FE7F, 1'b0, 4, 0};
        for (int v = 0; v < 7; v++)
            txn($sformatf("vec%0d", v), vecs[v].adr, vecs[v].rw, vecs[v].n, vecs[v].data,
                vecs[v].exp_ack, vecs[v].exp_nwr, vecs[v].exp_nrd);

        // Register write then repeated START and a one-byte read.
        wr0 = wr_tot; st0 = st_tot; rd0 = rd_tot;
        rd_src[0] = 8'hC3; rd_base = rd_tot;
        start_c();
        send_byte({7'h2A, 1'b0}, ack);
        check("rs addr_ack", ack, 0);
        send_byte(8'h05, ack);
        check("rs reg_ack", ack, 0);
        start_c();
        send_byte({7'h2A, 1'b1}, ack);
        check("rs raddr_ack", ack, 0);
        recv_byte(1'b1, b);
        check("rs rd_byte", b, 8'hC3);
        stop_c();
        check("rs wr_count", wr_tot - wr0, 1);
        check("rs wr0", wr_mem[wr0 % 1024], {1'b1, 8'h05});
        check("rs start_count", st_tot - st0, 2);
        check("rs rd_req_count", rd_tot - rd0, 1);

        // Reset while the target drives the address ACK.
        start_c();
        for (int i = 7; i >= 0; i--) send_bit(((8'h54 >> i) & 8'h01) != 0, s);
        check("rst ack_driven", sda_o, 0);
        rstb = 1'b1; w(1);
        check("rst sda_o", sda_o, 1);
        check("rst busy", busy, 0);
        rstb = 1'b0;
        send_bit(1'b1, s);
        stop_c();
        txn("after_rst", 7'h2A, 1'b0, 1, 32'h96000000, 1'b0, 1, 0);

        // STOP in the middle of a data byte.
        wr0 = wr_tot; sp0 = sp_tot;
        start_c();
        send_byte({7'h2A, 1'b0}, ack);
        check("part addr_ack", ack, 0);
        for (int i = 0; i < 4; i++) send_bit(i[0], s);
        stop_c();
        check("part wr_count", wr_tot - wr0, 0);
        check("part stop_count", sp_tot - sp0, 1);
        check("part busy", busy, 0);
        check("part sda_o", sda_o, 1);
        txn("after_part", 7'h2A, 1'b0, 1, 32'h5A000000, 1'b0, 1, 0);

        // Randomized transactions against the reference model.
        for (int t = 0; t < 16; t++) begin
            radr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h2A;
            rrw  = 1'($urandom);
            rn   = $urandom_range(1, 4);
            ref_model(radr, rrw, rn, rack, rnwr, rnrd);
            txn($sformatf("rnd%0d", t), radr, rrw, rn, $urandom, rack, rnwr, rnrd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
